// File: rtl/dft_dump_collector.sv
// dft_dump_collector: requests one scan dump from the DFT controller and captures strobed words into a show-ahead FIFO.
// Optional CAPT watchdog with ERR state is compiled in by defining DFT_COLLECT_TIMEOUT_EN.
module dft_dump_collector #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  output logic        o_busy,
  output logic        o_dft_val_op,
  input  logic        i_dft_op_ack,
  input  logic [31:0] i_dft_out,
  input  logic        i_dft_out_strobe,
  input  logic        i_dft_op_commit,
  output logic        o_dft_commit_ack,
  output logic [31:0] o_rd_data,
  output logic        o_rd_valid,
  input  logic        i_rd_ready,
  input  logic        i_clear,
  output logic        o_overflow,
  output logic [15:0] o_word_cnt,
  output logic        o_timeout_err
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1 || TIMEOUT > 65536) begin : g_bad_param
    $error("dft_dump_collector: illegal DEPTH or TIMEOUT");
  end

`ifdef DFT_COLLECT_TIMEOUT_EN
  typedef enum logic [2:0] {S_IDLE = 3'd0, S_REQ = 3'd1, S_CAPT = 3'd2, S_CACK = 3'd3, S_ERR = 3'd4} state_t;
`else
  typedef enum logic [2:0] {S_IDLE = 3'd0, S_REQ = 3'd1, S_CAPT = 3'd2, S_CACK = 3'd3} state_t;
`endif

  state_t r_state;
  state_t w_state_nxt;
  logic   w_start_acc;

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] w_rd_ptr_inc;
  logic [AW:0]   r_count;
  logic [31:0]   r_rd_data;
  logic [31:0]   w_rd_data_nxt;
  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          r_overflow;
  logic [15:0]   r_word_cnt;

`ifdef DFT_COLLECT_TIMEOUT_EN
  logic [15:0] r_tmo_cnt;
  logic        w_tmo_hit;
  logic        r_timeout_err;

  assign w_tmo_hit = (r_tmo_cnt == 16'(TIMEOUT - 1));
`endif

  // ---------------- FSM ----------------
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (i_start) w_state_nxt = S_REQ;
      S_REQ:  if (i_dft_op_ack) w_state_nxt = S_CAPT;
      S_CAPT: begin
        if (i_dft_op_commit) begin
          w_state_nxt = S_CACK;
`ifdef DFT_COLLECT_TIMEOUT_EN
        end else if (w_tmo_hit) begin
          w_state_nxt = S_ERR;
`endif
        end
      end
      S_CACK: w_state_nxt = S_IDLE;
`ifdef DFT_COLLECT_TIMEOUT_EN
      S_ERR:  if (i_start) w_state_nxt = S_REQ;
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy           = (r_state != S_IDLE);
    o_dft_val_op     = (r_state == S_REQ);
    o_dft_commit_ack = (r_state == S_CACK);
  end

`ifdef DFT_COLLECT_TIMEOUT_EN
  assign w_start_acc = i_start && (r_state == S_IDLE || r_state == S_ERR);
`else
  assign w_start_acc = i_start && (r_state == S_IDLE);
`endif

  // ---------------- Capture FIFO ----------------
  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == FULL_CNT);
  assign w_pop        = i_rd_ready & ~w_empty & ~i_clear;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts the strobe.
  assign w_push       = i_dft_out_strobe & (~w_full | w_pop) & ~i_clear;
  assign w_rd_ptr_inc = r_rd_ptr + 1'b1;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_dft_out;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= w_rd_ptr_inc;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Registered head copy: keeps rd_data defined after reset and holds it while empty.
  always_comb begin
    w_rd_data_nxt = r_rd_data;
    if (w_pop) begin
      if (r_count > ONE_CNT) begin
        w_rd_data_nxt = r_mem[w_rd_ptr_inc];
      end else if (w_push) begin
        w_rd_data_nxt = i_dft_out;
      end
    end else if (w_push && w_empty) begin
      w_rd_data_nxt = i_dft_out;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= w_rd_data_nxt;
    end
  end

  // ---------------- Status ----------------
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_overflow <= 1'b0;
    end else if (i_clear) begin
      r_overflow <= 1'b0;
    end else if (i_dft_out_strobe && w_full && !w_pop) begin
      r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_word_cnt <= '0;
    end else if (w_start_acc) begin
      r_word_cnt <= '0;
    end else if (i_dft_out_strobe && r_word_cnt != 16'hFFFF) begin
      r_word_cnt <= r_word_cnt + 16'd1;
    end
  end

`ifdef DFT_COLLECT_TIMEOUT_EN
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_tmo_cnt <= '0;
    end else if (r_state == S_CAPT) begin
      r_tmo_cnt <= r_tmo_cnt + 16'd1;
    end else begin
      r_tmo_cnt <= '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_timeout_err <= 1'b0;
    end else if (i_clear) begin
      r_timeout_err <= 1'b0;
    end else if (r_state == S_CAPT && !i_dft_op_commit && w_tmo_hit) begin
      r_timeout_err <= 1'b1;
    end
  end

  assign o_timeout_err = r_timeout_err;
`else
  assign o_timeout_err = 1'b0;
`endif

  assign o_rd_data  = r_rd_data;
  assign o_rd_valid = ~w_empty;
  assign o_overflow = r_overflow;
  assign o_word_cnt = r_word_cnt;

endmodule
